// File: rtl/tlk2711_rx_checker.sv
// Receive-side checker for a TLK2711 16-bit parallel bus: idle-based word sync,
// SOF/EOF frame delimiting, payload pattern checking and saturating counters.
module tlk2711_rx_checker #(
  parameter int SYNC_IDLES = 16,
  parameter int LOSS_ERRS  = 4,
  parameter int MAX_LEN    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_rxd,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  input  logic [2:0]  i_mode,
  input  logic        i_clear,
  output logic        o_sync,
  output logic [15:0] o_data,
  output logic        o_data_valid,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [15:0] o_last_len,
  output logic [31:0] o_frame_cnt,
  output logic [31:0] o_word_err_cnt
);

  localparam int IW = $clog2(SYNC_IDLES) + 1;
  localparam int EW = $clog2(LOSS_ERRS) + 1;

  typedef enum logic [2:0] {C_IDLE, C_SOF, C_EOF, C_ERR, C_DATA} word_cls_e;
  typedef enum logic       {S_UNSYNC, S_SYNCED} sync_state_e;
  typedef enum logic [1:0] {F_WAIT_SOF, F_IN_FRAME, F_DISCARD} frame_state_e;

  // Input register stage; mode travels with its word so SOF latches the aligned value.
  logic [15:0] rxd_q;
  logic [1:0]  k_q;
  logic [2:0]  mode_in_q;

  sync_state_e  sync_q, sync_d;
  frame_state_e frame_q, frame_d;
  logic [IW-1:0] idle_run_q, idle_run_d;
  logic [EW-1:0] err_run_q, err_run_d;
  logic [2:0]  mode_q, mode_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] len_q, len_d;
  logic [15:0] data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] last_len_q, last_len_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] word_err_q, word_err_d;

  word_cls_e cls;
  logic      lose_sync;
  logic      frame_inc;
  logic      word_err_inc;

  always_comb begin
    cls = C_ERR;
    case (k_q)
      2'b00: cls = C_DATA;
      2'b01: cls = (rxd_q == 16'h50BC) ? C_IDLE : C_ERR;
      2'b11: begin
        if (rxd_q == 16'hFBFB)      cls = C_SOF;
        else if (rxd_q == 16'hFDFD) cls = C_EOF;
        else                        cls = C_ERR;
      end
      default: cls = C_ERR;
    endcase
  end

  always_comb begin
    sync_d       = sync_q;
    idle_run_d   = idle_run_q;
    err_run_d    = err_run_q;
    lose_sync    = 1'b0;
    case (sync_q)
      S_UNSYNC: begin
        err_run_d = '0;
        if (cls == C_IDLE) begin
          if (idle_run_q == IW'(SYNC_IDLES - 1)) begin
            sync_d     = S_SYNCED;
            idle_run_d = '0;
          end else begin
            idle_run_d = idle_run_q + 1'b1;
          end
        end else begin
          idle_run_d = '0;
        end
      end
      S_SYNCED: begin
        idle_run_d = '0;
        if (cls == C_ERR) begin
          if (err_run_q == EW'(LOSS_ERRS - 1)) begin
            sync_d    = S_UNSYNC;
            err_run_d = '0;
            lose_sync = 1'b1;
          end else begin
            err_run_d = err_run_q + 1'b1;
          end
        end else begin
          err_run_d = '0;
        end
      end
      default: sync_d = S_UNSYNC;
    endcase
  end

  // SOF always opens a fresh frame, whatever state it arrives in.
  always_comb begin
    frame_d      = frame_q;
    mode_d       = mode_q;
    exp_d        = exp_q;
    len_d        = len_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    frame_inc    = 1'b0;
    word_err_inc = 1'b0;
    last_len_d   = last_len_q;
    if (sync_q == S_SYNCED) begin
      if (cls == C_SOF) begin
        err_d   = (frame_q == F_IN_FRAME);
        frame_d = F_IN_FRAME;
        mode_d  = mode_in_q;
        len_d   = '0;
        exp_d   = (mode_in_q == 3'd1) ? 16'hA5A5 : 16'h0000;
      end else begin
        case (frame_q)
          F_WAIT_SOF: begin
            if (cls == C_DATA || cls == C_EOF) word_err_inc = 1'b1;
          end
          F_IN_FRAME: begin
            case (cls)
              C_DATA: begin
                if (len_q == 16'(MAX_LEN)) begin
                  err_d   = 1'b1;
                  frame_d = F_DISCARD;
                end else begin
                  data_d       = rxd_q;
                  data_valid_d = 1'b1;
                  len_d        = len_q + 16'd1;
                  if (mode_q == 3'd0) begin
                    word_err_inc = (rxd_q != exp_q);
                    exp_d        = exp_q + 16'd1;
                  end else if (mode_q == 3'd1) begin
                    word_err_inc = (rxd_q != exp_q);
                    exp_d        = ~exp_q;
                  end
                end
              end
              C_EOF: begin
                done_d     = 1'b1;
                frame_inc  = 1'b1;
                last_len_d = len_q;
                frame_d    = F_WAIT_SOF;
              end
              C_ERR:   word_err_inc = 1'b1;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      if (lose_sync) begin
        err_d   = (frame_q == F_IN_FRAME);
        done_d  = 1'b0;
        frame_d = F_WAIT_SOF;
      end
    end else begin
      frame_d = F_WAIT_SOF;
    end

    frame_cnt_d = frame_cnt_q;
    word_err_d  = word_err_q;
    if (frame_inc && frame_cnt_q != 32'hFFFF_FFFF)   frame_cnt_d = frame_cnt_q + 32'd1;
    if (word_err_inc && word_err_q != 32'hFFFF_FFFF) word_err_d  = word_err_q + 32'd1;
    if (i_clear) begin
      frame_cnt_d = '0;
      word_err_d  = '0;
      last_len_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q        <= '0;
      k_q          <= '0;
      mode_in_q    <= '0;
      sync_q       <= S_UNSYNC;
      frame_q      <= F_WAIT_SOF;
      idle_run_q   <= '0;
      err_run_q    <= '0;
      mode_q       <= '0;
      exp_q        <= '0;
      len_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      last_len_q   <= '0;
      frame_cnt_q  <= '0;
      word_err_q   <= '0;
    end else begin
      rxd_q        <= i_rxd;
      k_q          <= {i_rkmsb, i_rklsb};
      mode_in_q    <= i_mode;
      sync_q       <= sync_d;
      frame_q      <= frame_d;
      idle_run_q   <= idle_run_d;
      err_run_q    <= err_run_d;
      mode_q       <= mode_d;
      exp_q        <= exp_d;
      len_q        <= len_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      last_len_q   <= last_len_d;
      frame_cnt_q  <= frame_cnt_d;
      word_err_q   <= word_err_d;
    end
  end

  assign o_sync         = (sync_q == S_SYNCED);
  assign o_data         = data_q;
  assign o_data_valid   = data_valid_q;
  assign o_frame_done   = done_q;
  assign o_frame_err    = err_q;
  assign o_last_len     = last_len_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_word_err_cnt = word_err_q;

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// Directed vector bench for tlk2711_rx_checker (MAX_LEN shrunk to 10 to reach the length limit).
module tb_tlk2711_rx_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_rxd;
  logic        i_rkmsb, i_rklsb;
  logic [2:0]  i_mode;
  logic        i_clear;
  logic        o_sync;
  logic [15:0] o_data;
  logic        o_data_valid, o_frame_done, o_frame_err;
  logic [15:0] o_last_len;
  logic [31:0] o_frame_cnt, o_word_err_cnt;

  tlk2711_rx_checker #(.SYNC_IDLES(16), .LOSS_ERRS(4), .MAX_LEN(10)) dut (
    .clk(clk), .rst(rst), .i_rxd(i_rxd), .i_rkmsb(i_rkmsb), .i_rklsb(i_rklsb),
    .i_mode(i_mode), .i_clear(i_clear), .o_sync(o_sync), .o_data(o_data),
    .o_data_valid(o_data_valid), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
    .o_last_len(o_last_len), .o_frame_cnt(o_frame_cnt), .o_word_err_cnt(o_word_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  k;
    logic [15:0] d;
    logic [2:0]  mode;
    logic        ev;
    logic [15:0] ed;
    logic        edone;
    logic        eerr;
    logic        esync;
    logic [31:0] efc;
    logic [31:0] eec;
    logic [15:0] ell;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  logic        e_sync = 1'b0;
  logic [31:0] e_fc = 0, e_ec = 0;
  logic [15:0] e_ll = 0;

  function automatic void add(logic [1:0] k, logic [15:0] d, logic [2:0] mode,
                              logic ev, logic [15:0] ed, logic edone, logic eerr);
    vec_t v;
    v.k = k; v.d = d; v.mode = mode; v.ev = ev; v.ed = ed;
    v.edone = edone; v.eerr = eerr; v.esync = e_sync;
    v.efc = e_fc; v.eec = e_ec; v.ell = e_ll;
    vecs.push_back(v);
  endfunction

  function automatic void w_idle();                  add(2'b01, 16'h50BC, 3'd0, 0, 0, 0, 0); endfunction
  function automatic void w_sof(logic [2:0] m);      add(2'b11, 16'hFBFB, m, 0, 0, 0, 0);    endfunction
  function automatic void w_dat(logic [15:0] d);     add(2'b00, d, 3'd0, 1, d, 0, 0);         endfunction
  function automatic void w_drop(logic [15:0] d);    add(2'b00, d, 3'd0, 0, 0, 0, 0);         endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic [1:0] k, logic [15:0] d, logic [2:0] m);
    i_rkmsb = k[1]; i_rklsb = k[0]; i_rxd = d; i_mode = m;
  endtask

  task automatic cmp_vec(int idx);
    vec_t v;
    v = vecs[idx];
    chk("data_valid", idx, 32'(o_data_valid), 32'(v.ev));
    if (v.ev) chk("data", idx, 32'(o_data), 32'(v.ed));
    chk("frame_done", idx, 32'(o_frame_done), 32'(v.edone));
    chk("frame_err", idx, 32'(o_frame_err), 32'(v.eerr));
    chk("sync", idx, 32'(o_sync), 32'(v.esync));
    chk("frame_cnt", idx, o_frame_cnt, v.efc);
    chk("word_err_cnt", idx, o_word_err_cnt, v.eec);
    chk("last_len", idx, 32'(o_last_len), 32'(v.ell));
  endtask

  initial begin
    rst = 1'b1; i_clear = 1'b0;
    drive(2'b01, 16'h50BC, 3'd0);

    // Sync acquisition: interrupted run of 15, then a full run of 16.
    for (int i = 0; i < 15; i++) w_idle();
    w_drop(16'h1234);
    for (int i = 0; i < 15; i++) w_idle();
    e_sync = 1'b1;
    w_idle();
    // Mode 0 frame of exactly MAX_LEN words.
    w_sof(3'd0);
    for (int i = 0; i < 10; i++) w_dat(16'(i));
    e_fc = 1; e_ll = 10;
    add(2'b11, 16'hFDFD, 3'd0, 0, 0, 1, 0);
    // Mode 1 frame with one corrupted word.
    w_idle();
    w_sof(3'd1);
    w_dat(16'hA5A5); w_dat(16'h5A5A); w_dat(16'hA5A5);
    e_ec = 1;
    w_dat(16'hFFFF);
    w_dat(16'hA5A5);
    e_fc = 2; e_ll = 5;
    add(2'b11, 16'hFDFD, 3'd0, 0, 0, 1, 0);
    // Stray DATA and EOF outside a frame.
    e_ec = 2; w_drop(16'h1111);
    e_ec = 3; add(2'b11, 16'hFDFD, 3'd0, 0, 0, 0, 0);
    // SOF inside a frame aborts and restarts.
    w_sof(3'd0);
    w_dat(16'h0000); w_dat(16'h0001); w_dat(16'h0002);
    add(2'b11, 16'hFBFB, 3'd0, 0, 0, 0, 1);
    w_dat(16'h0000); w_idle(); w_dat(16'h0001);
    e_fc = 3; e_ll = 2;
    add(2'b11, 16'hFDFD, 3'd0, 0, 0, 1, 0);
    // Length overflow: 11th word errors, rest discarded until next SOF.
    w_sof(3'd2);
    for (int i = 0; i < 10; i++) w_dat(16'hC000 + 16'(i));
    add(2'b00, 16'hC00A, 3'd0, 0, 0, 0, 1);
    add(2'b11, 16'hFDFD, 3'd0, 0, 0, 0, 0);
    w_drop(16'h7777);
    w_sof(3'd0);
    w_dat(16'h0000);
    e_fc = 4; e_ll = 1;
    add(2'b11, 16'hFDFD, 3'd0, 0, 0, 1, 0);
    // Four consecutive code errors mid-frame drop sync.
    w_sof(3'd0);
    w_dat(16'h0000);
    e_ec = 4; add(2'b11, 16'hFEFE, 3'd0, 0, 0, 0, 0);
    e_ec = 5; add(2'b10, 16'h0000, 3'd0, 0, 0, 0, 0);
    e_ec = 6; add(2'b01, 16'h1234, 3'd0, 0, 0, 0, 0);
    e_ec = 7; e_sync = 1'b0;
    add(2'b11, 16'hFEFE, 3'd0, 0, 0, 0, 1);
    w_idle(); w_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sync", -1, 32'(o_sync), 0);
    chk("rst_valid", -1, 32'(o_data_valid), 0);
    chk("rst_data", -1, 32'(o_data), 0);
    chk("rst_frame_cnt", -1, o_frame_cnt, 0);
    chk("rst_word_err_cnt", -1, o_word_err_cnt, 0);
    chk("rst_last_len", -1, 32'(o_last_len), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i <= vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (i < vecs.size()) drive(vecs[i].k, vecs[i].d, vecs[i].mode);
      else drive(2'b01, 16'h50BC, 3'd0);
      @(posedge clk); #1;
      if (i >= 1) cmp_vec(i - 1);
    end

    // Counter clear.
    @(negedge clk); i_clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_frame_cnt", -2, o_frame_cnt, 0);
    chk("clear_word_err_cnt", -2, o_word_err_cnt, 0);
    chk("clear_last_len", -2, 32'(o_last_len), 0);
    @(negedge clk); i_clear = 1'b0;

    // Resync, open a frame, then reset mid-frame: no frame error may appear.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); drive(2'b01, 16'h50BC, 3'd0);
    end
    @(negedge clk); drive(2'b11, 16'hFBFB, 3'd0);
    @(negedge clk); drive(2'b00, 16'h0000, 3'd0);
    @(negedge clk); drive(2'b00, 16'h0001, 3'd0);
    @(posedge clk); #1;
    chk("resync", -3, 32'(o_sync), 1);
    chk("resync_valid", -3, 32'(o_data_valid), 1);
    @(negedge clk); rst = 1'b1; drive(2'b00, 16'h0002, 3'd0);
    @(negedge clk); rst = 1'b0; drive(2'b11, 16'hFDFD, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(2'b01, 16'h50BC, 3'd0);
      chk("rst_mid_frame_err", -4, 32'(o_frame_err), 0);
      chk("rst_mid_sync", -4, 32'(o_sync), 0);
      chk("rst_mid_done", -4, 32'(o_frame_done), 0);
    end
    chk("rst_mid_frame_cnt", -4, o_frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
